// File: rtl/add_pkg.sv
// Shared defaults and helpers for the pipelined carry-select adder.
package add_pkg;

   localparam int DEF_WIDTH        = 64;
   localparam int DEF_SEG_W        = 16;
   localparam int DEF_SEGS_PER_STG = 1;

   function automatic int calc_lat(input int width, input int seg_w, input int sps);
      return (width / seg_w) / sps;
   endfunction

endpackage

// File: rtl/csel_seg.sv
// One segment of the adder: a plain ripple adder at a stage head,
// or a carry-select pair muxed on the incoming carry elsewhere.
module csel_seg
   import add_pkg::*;
#(
   parameter int SEG_W = DEF_SEG_W
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin_sel,
   input  logic             use_select,
   output logic [SEG_W-1:0] s,
   output logic             cout
);

   logic [SEG_W:0] r0;
   logic [SEG_W:0] r1;
   logic [SEG_W:0] rs;

   always_comb begin
      r0 = '0;
      r1 = '0;
      rs = '0;
      if (use_select) begin
         r0 = {1'b0, a} + {1'b0, b};
         r1 = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, 1'b1};
         rs = cin_sel ? r1 : r0;
      end else begin
         rs = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin_sel};
      end
   end

   assign s    = rs[SEG_W-1:0];
   assign cout = rs[SEG_W];

endmodule

// File: rtl/pipe_add_cs.sv
// Pipelined carry-select adder/subtractor with a global-stall
// valid/ready handshake; one stage register per group of segments.
module pipe_add_cs
   import add_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int SEG_W        = DEF_SEG_W,
   parameter int SEGS_PER_STG = DEF_SEGS_PER_STG
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSEG = WIDTH / SEG_W;
   localparam int SPS  = SEGS_PER_STG;
   localparam int LAT  = calc_lat(WIDTH, SEG_W, SEGS_PER_STG);

   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] s;
      logic             c;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cm;
   } stg_t;

   if ((WIDTH % SEG_W) != 0 || (NSEG % SEGS_PER_STG) != 0) begin : g_bad_param
      $fatal(1, "pipe_add_cs: WIDTH/SEG_W/SEGS_PER_STG do not divide evenly");
   end

   stg_t             st  [LAT];
   stg_t             cur [LAT];
   stg_t             nxt [LAT];
   logic [WIDTH-1:0] seg_sum;
   logic [NSEG-1:0]  seg_co;
   logic             adv;

   assign adv      = !st[LAT-1].v || out_ready;
   assign in_ready = adv;

   // Stage 0 works on the inverted operand; later stages on the registers.
   always_comb begin
      cur[0]   = '0;
      cur[0].v = in_valid;
      cur[0].a = a;
      cur[0].b = b ^ {WIDTH{sub}};
      cur[0].c = cin ^ sub;
      for (int k = 1; k < LAT; k++) cur[k] = st[k-1];
   end

   for (genvar j = 0; j < NSEG; j++) begin : g_seg
      localparam int K     = j / SPS;
      localparam bit FIRST = (j % SPS) == 0;
      logic ci;
      logic co;
      if (FIRST) begin : g_head
         assign ci = cur[K].c;
      end else begin : g_tail
         assign ci = g_seg[j-1].co;
      end
      csel_seg #(.SEG_W(SEG_W)) u_seg (
         .a          (cur[K].a[j*SEG_W +: SEG_W]),
         .b          (cur[K].b[j*SEG_W +: SEG_W]),
         .cin_sel    (ci),
         .use_select (FIRST ? 1'b0 : 1'b1),
         .s          (seg_sum[j*SEG_W +: SEG_W]),
         .cout       (co)
      );
      assign seg_co[j] = co;
   end

   always_comb begin
      for (int k = 0; k < LAT; k++) begin
         nxt[k] = cur[k];
         for (int i = k*SPS; i < (k+1)*SPS; i++)
            nxt[k].s[i*SEG_W +: SEG_W] = seg_sum[i*SEG_W +: SEG_W];
         nxt[k].c = seg_co[(k+1)*SPS-1];
      end
      // Carry into the MSB, recovered from the MSB sum bit.
      nxt[LAT-1].cm = cur[LAT-1].a[WIDTH-1] ^ cur[LAT-1].b[WIDTH-1]
                    ^ seg_sum[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) st[k] <= '0;
      end else if (adv) begin
         for (int k = 0; k < LAT; k++) st[k] <= nxt[k];
      end
   end

   assign out_valid = st[LAT-1].v;
   assign sum       = st[LAT-1].s;
   assign cout      = st[LAT-1].c;
   assign ovf       = st[LAT-1].cm ^ st[LAT-1].c;
   assign zero      = ~|st[LAT-1].s;

endmodule

// File: tb/tb_pipe_add_cs.sv
// Bench for pipe_add_cs: directed corners, random streaming with
// backpressure, and three alternate segmentations.
module tb_pipe_add_cs;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, in_ready, cin, sub;
   logic        out_valid, out_ready, cout, ovf, zero;
   logic [63:0] a, b, sum;

   int errors = 0;
   int checks = 0;

   pipe_add_cs dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   logic [127:0] sw_a, sw_b;
   logic         sw_cin, sw_sub;
   logic [2:0]   sw_iv, sw_ir, sw_ov, sw_co, sw_of, sw_z;
   logic [31:0]  o0_sum;
   logic [63:0]  o1_sum;
   logic [127:0] o2_sum;

   pipe_add_cs #(.WIDTH(32), .SEG_W(8), .SEGS_PER_STG(2)) dut_w32 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]),
      .a(sw_a[31:0]), .b(sw_b[31:0]), .cin(sw_cin), .sub(sw_sub),
      .out_valid(sw_ov[0]), .out_ready(1'b1), .sum(o0_sum),
      .cout(sw_co[0]), .ovf(sw_of[0]), .zero(sw_z[0])
   );

   pipe_add_cs #(.WIDTH(64), .SEG_W(16), .SEGS_PER_STG(4)) dut_w64 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]),
      .a(sw_a[63:0]), .b(sw_b[63:0]), .cin(sw_cin), .sub(sw_sub),
      .out_valid(sw_ov[1]), .out_ready(1'b1), .sum(o1_sum),
      .cout(sw_co[1]), .ovf(sw_of[1]), .zero(sw_z[1])
   );

   pipe_add_cs #(.WIDTH(128), .SEG_W(16), .SEGS_PER_STG(1)) dut_w128 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]),
      .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
      .out_valid(sw_ov[2]), .out_ready(1'b1), .sum(o2_sum),
      .cout(sw_co[2]), .ovf(sw_of[2]), .zero(sw_z[2])
   );

   // Reference: integer arithmetic on w-bit operands -> {ovf, cout, sum}.
   function automatic logic [129:0] ref_op(input int w, input logic [127:0] x,
                                           input logic [127:0] y,
                                           input logic ci, input logic sb);
      logic [131:0]        one, m, ux, uy, uc, t;
      logic signed [131:0] sx, sy, sc, r, lim;
      logic                co, ov;
      one = 132'd1;
      m   = (one << w) - one;
      ux  = {4'd0, x} & m;
      uy  = {4'd0, y} & m;
      uc  = {131'd0, ci};
      sc  = $signed(uc);
      if (sb) begin
         t  = ux - uy - uc;
         co = (ux >= uy + uc);
      end else begin
         t  = ux + uy + uc;
         co = t[w];
      end
      t   = t & m;
      sx  = ux[w-1] ? $signed(ux - (one << w)) : $signed(ux);
      sy  = uy[w-1] ? $signed(uy - (one << w)) : $signed(uy);
      r   = sb ? (sx - sy - sc) : (sx + sy + sc);
      lim = $signed(one << (w - 1));
      ov  = (r >= lim) || (r < -lim);
      return {ov, co, t[127:0]};
   endfunction

   function automatic logic [127:0] rnd();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return {4{32'h8000_0000}};
         3:       return {4{32'h7FFF_FFFF}};
         default: return {$urandom(), $urandom(), $urandom(), $urandom()};
      endcase
   endfunction

   task automatic run_one(input logic [63:0] x, input logic [63:0] y,
                          input logic ci, input logic sb,
                          output logic [63:0] s, output logic co,
                          output logic ov, output logic z, output int lat);
      @(posedge clk); #1;
      in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      s = sum; co = cout; ov = ovf; z = zero;
   endtask

   task automatic test_reset();
      logic [129:0] e;
      logic [63:0]  x, y;
      int           lat;
      @(posedge clk); #1;
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      a = 64'(rnd()); b = 64'(rnd()); cin = 1'b0; sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || sum !== 64'd0 || zero !== 1'b1 ||
             cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state cyc%0d: valid=%b sum=%h zero=%b cout=%b ovf=%b, want 0 0 1 0 0",
                     i, out_valid, sum, zero, cout, ovf);
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready cyc%0d: got %b want 1", i, in_ready);
         end
         a = 64'(rnd()); b = 64'(rnd());
      end
      x = 64'h0123_4567_89AB_CDEF; y = 64'hFEDC_BA98_7654_3210;
      rst_n = 1'b1; a = x; b = y; cin = 1'b1; sub = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL reset_first_latency: got %0d want 4", lat);
      end
      e = ref_op(64, {64'd0, x}, {64'd0, y}, 1'b1, 1'b0);
      checks++;
      if ({ovf, cout, 64'd0, sum} !== e) begin
         errors++;
         $display("FAIL reset_first_result: got %h want %h",
                  {ovf, cout, 64'd0, sum}, e);
      end
   endtask

   task automatic test_carry_chain();
      logic [63:0] s;
      logic        co, ov, z;
      int          lat;
      run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, s, co, ov, z, lat);
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL carry_latency: got %0d want 4", lat);
      end
      checks++;
      if (s !== 64'd0 || co !== 1'b1 || z !== 1'b1 || ov !== 1'b0) begin
         errors++;
         $display("FAIL carry_chain: sum=%h cout=%b zero=%b ovf=%b, want 0 1 1 0",
                  s, co, z, ov);
      end
   endtask

   task automatic test_sub_ovf();
      logic [63:0] s;
      logic        co, ov, z;
      int          lat;
      run_one(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, s, co, ov, z, lat);
      checks++;
      if (s !== 64'h7FFF_FFFF_FFFF_FFFF || ov !== 1'b1 || co !== 1'b1 ||
          z !== 1'b0 || lat != 4) begin
         errors++;
         $display("FAIL sub_ovf: sum=%h ovf=%b cout=%b zero=%b lat=%0d, want 7fffffffffffffff 1 1 0 4",
                  s, ov, co, z, lat);
      end
      run_one(64'd5, 64'd7, 1'b0, 1'b1, s, co, ov, z, lat);
      checks++;
      if (s !== 64'hFFFF_FFFF_FFFF_FFFE || ov !== 1'b0 || co !== 1'b0 ||
          z !== 1'b0 || lat != 4) begin
         errors++;
         $display("FAIL sub_borrow: sum=%h ovf=%b cout=%b zero=%b lat=%0d, want fffffffffffffffe 0 0 0 4",
                  s, ov, co, z, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [129:0] q[$];
      logic [129:0] e;
      int           sent, got, first, last;
      sent = 0; got = 0; first = -1; last = -1;
      for (int cyc = 0; cyc < 200 && got < 100; cyc++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         in_valid  = (sent < 100);
         a = 64'(rnd()); b = 64'(rnd());
         cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         #1;
         if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra_beat: unexpected output sum=%h", sum);
            end else begin
               e = q.pop_front();
               if ({ovf, cout, 64'd0, sum} !== e || zero !== (e[127:0] == '0)) begin
                  errors++;
                  $display("FAIL b2b_result #%0d: got %h z=%b want %h",
                           got, {ovf, cout, 64'd0, sum}, zero, e);
               end
            end
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back(ref_op(64, {64'd0, a}, {64'd0, b}, cin, sub));
            sent++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (got != 100) begin
         errors++;
         $display("FAIL b2b_count: got %0d want 100", got);
      end
      checks++;
      if (last - first != 99) begin
         errors++;
         $display("FAIL b2b_gapless: span %0d want 99", last - first);
      end
   endtask

   task automatic test_backpressure();
      logic [129:0] q[$];
      logic [129:0] e;
      logic [66:0]  hold;
      logic         held, acc;
      int           sent, got;
      sent = 0; got = 0; held = 1'b0; acc = 1'b1; hold = '0;
      for (int cyc = 0; cyc < 150 && got < 30; cyc++) begin
         @(posedge clk); #1;
         out_ready = !(cyc >= 8 && cyc < 13);
         if (acc) begin
            a = 64'(rnd()); b = 64'(rnd());
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         end
         in_valid = (sent < 30);
         #1;
         if (!out_ready) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL bp_stall cyc%0d: in_ready=%b out_valid=%b want 0 1",
                        cyc, in_ready, out_valid);
            end
            if (held) begin
               checks++;
               if ({ovf, cout, zero, sum} !== hold) begin
                  errors++;
                  $display("FAIL bp_hold cyc%0d: got %h want %h",
                           cyc, {ovf, cout, zero, sum}, hold);
               end
            end
            hold = {ovf, cout, zero, sum};
            held = 1'b1;
         end else begin
            held = 1'b0;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra_beat: unexpected output sum=%h", sum);
            end else begin
               e = q.pop_front();
               if ({ovf, cout, 64'd0, sum} !== e || zero !== (e[127:0] == '0)) begin
                  errors++;
                  $display("FAIL bp_result #%0d: got %h want %h",
                           got, {ovf, cout, 64'd0, sum}, e);
               end
            end
            got++;
         end
         acc = in_valid && in_ready;
         if (acc) begin
            q.push_back(ref_op(64, {64'd0, a}, {64'd0, b}, cin, sub));
            sent++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (got != 30 || q.size() != 0) begin
         errors++;
         $display("FAIL bp_count: got %0d left %0d want 30 0", got, q.size());
      end
   endtask

   task automatic test_param_sweep();
      logic [129:0] q[$];
      logic [129:0] e, obs;
      logic         v, ir, zz;
      int           w, elat, sent, got, first_acc;
      for (int d = 0; d < 3; d++) begin
         w    = (d == 0) ? 32 : (d == 1) ? 64 : 128;
         elat = (d == 0) ? 2 : (d == 1) ? 1 : 8;
         sent = 0; got = 0; first_acc = -1;
         q.delete();
         for (int cyc = 0; cyc < 150 && got < 40; cyc++) begin
            @(posedge clk); #1;
            sw_a = rnd(); sw_b = rnd();
            sw_cin = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
            sw_iv    = '0;
            sw_iv[d] = (sent < 40);
            #1;
            case (d)
               0:       obs = {sw_of[0], sw_co[0], 96'd0, o0_sum};
               1:       obs = {sw_of[1], sw_co[1], 64'd0, o1_sum};
               default: obs = {sw_of[2], sw_co[2], o2_sum};
            endcase
            v = sw_ov[d]; ir = sw_ir[d]; zz = sw_z[d];
            if (v) begin
               if (got == 0) begin
                  checks++;
                  if (cyc - first_acc != elat) begin
                     errors++;
                     $display("FAIL sweep_lat w%0d: got %0d want %0d",
                              w, cyc - first_acc, elat);
                  end
               end
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL sweep_extra_beat w%0d: got %h", w, obs);
               end else begin
                  e = q.pop_front();
                  if (obs !== e || zz !== (e[127:0] == '0)) begin
                     errors++;
                     $display("FAIL sweep_result w%0d #%0d: got %h z=%b want %h",
                              w, got, obs, zz, e);
                  end
               end
               got++;
            end
            if (sw_iv[d] && ir) begin
               if (first_acc < 0) first_acc = cyc;
               q.push_back(ref_op(w, sw_a, sw_b, sw_cin, sw_sub));
               sent++;
            end
         end
         sw_iv = '0;
         checks++;
         if (got != 40) begin
            errors++;
            $display("FAIL sweep_count w%0d: got %0d want 40", w, got);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_iv = '0;
      test_reset();
      test_carry_chain();
      test_sub_ovf();
      test_back_to_back();
      test_backpressure();
      test_param_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

endmodule
